md_unit: RTL
============

// Module: md_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with HI/LO registers, in the EX stage beside the ALU.
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E-stage control and runs multiply/divide for a fixed latency.
//   busy drives stall control: a D-stage MD-class instr stalls while (start | busy).
//   hi/lo feed MFHI/MFLO through the E-stage result mux.
// PARAMETERS
//   WIDTH        32  operand / HI / LO width in bits (>= 2)
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>= 1)
// PORTS
//   clk    in   1      clock; all state updates on rising edge
//   reset  in   1      synchronous, active-high reset
//   start  in   1      op valid this cycle (E-stage instr is MD-class)
//   op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a      in   WIDTH  operand rs (dividend / MTHI/MTLO source)
//   b      in   WIDTH  operand rt (divisor)
//   busy   out  1      multiply/divide in progress
//   done   out  1      one-cycle pulse: hi/lo just committed by mult/div
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// BEHAVIOUR
//   Reset: busy=0, done=0, hi=0, lo=0, counter=0, latched operands/op cleared. Reset overrides every other input.
//   Reset mid-operation aborts: no commit, no done pulse.
//   Accept: start=1 & busy=0 & op in {0..3} at edge t.
//     Latch a, b, op; counter <= N-1 (N = MULT_CYCLES or DIV_CYCLES).
//     busy=1 during cycles t+1 .. t+N; counter decrements each edge while busy.
//     Commit on the edge ending cycle t+N (counter==0 & busy): hi/lo <= result, busy <= 0, done <= 1.
//     Commit and done pulse occur even when the result is suppressed (div by zero).
//     New hi/lo and done=1 visible in cycle t+N+1; done=0 the cycle after.
//   Back-to-back: start with busy=0 in the cycle done=1 is accepted normally.
//   MTHI/MTLO: start=1 & busy=0 -> hi (resp. lo) <= a at that edge; busy stays 0, no done pulse.
//   start=1 while busy=1 is ignored for every op: no re-latch, no MTHI/MTLO write, timing unchanged.
//   op 6-7 with start=1: no effect.
//   Arithmetic (uses latched operands; results independent of a/b after accept):
//     MULT:  {hi,lo} <= signed(a)*signed(b), full 2*WIDTH product.
//     MULTU: {hi,lo} <= unsigned(a)*unsigned(b).
//     DIV:   lo <= quotient truncated toward zero; hi <= remainder, sign of dividend.
//     DIVU:  lo <= a/b, hi <= a%b, unsigned.
//     DIV overflow (a = most negative, b = -1): lo <= most negative, hi <= 0.
//     b == 0 (DIV/DIVU): hi/lo keep previous values; busy timing and done pulse unchanged.
//   Implementation is free (iterative or combinational+delay) if the cycle timing above is exact.
//   hi/lo change only at reset, an MTHI/MTLO write, or a commit.
// TESTING
//   Reset: hold reset 2 cycles -> busy=0, done=0, hi=0, lo=0.
//   MULT a=0xFFFFFFFD(-3), b=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done 1 cycle.
//   DIVU a=100, b=7 -> 10 busy cycles, lo=14, hi=2.
//   DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//   DIV b=0 with prior hi=0x11, lo=0x22 -> unchanged after 10 busy cycles; done pulses.
//   During MULT busy: start with MTHI a=0x55, then DIVU -> both ignored; MULT result committed at original time.
//   MTLO a=0xABCD idle -> lo=0xABCD next cycle, busy stays 0.
//   Reset asserted in 3rd busy cycle of DIV -> busy=0, hi=lo=0, no done pulse.
//   Build with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=1: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 after 1 busy cycle.
//   Same build: back-to-back start in the done cycle -> accepted.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Operands are latched on accept; the result is produced when the fixed busy window ends.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  // Full-width product; signed operands are sign-extended to 2*WIDTH first.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn);
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}; quotient truncates toward zero and the
  // remainder follows the dividend's sign. The most-negative / -1 case
  // naturally wraps back to the most-negative quotient with zero remainder.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn);
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] ux;
    logic [WIDTH-1:0] uy;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    neg_x = sgn & x[WIDTH-1];
    neg_y = sgn & y[WIDTH-1];
    ux    = neg_x ? (~x + 1'b1) : x;
    uy    = neg_y ? (~y + 1'b1) : y;
    if (uy == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ux / uy;
      r = ux % uy;
    end
    if (neg_x ^ neg_y) q = ~q + 1'b1;
    if (neg_x)         r = ~r + 1'b1;
    return {r, q};
  endfunction

  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [1:0]         op_p0;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] res_p0;
  logic               div_zero_p0;

  // Stage p0: result from latched operands, consumed at the commit edge.
  always_comb begin
    res_p0      = '0;
    div_zero_p0 = 1'b0;
    if (op_p0[1]) begin
      res_p0      = div_full(a_p0, b_p0, ~op_p0[0]);
      div_zero_p0 = (b_p0 == '0);
    end else begin
      res_p0      = mul_full(a_p0, b_p0, ~op_p0[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!div_zero_p0) begin
            hi <= res_p0[2*WIDTH-1:WIDTH];
            lo <= res_p0[WIDTH-1:0];
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (start) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            a_p0  <= a;
            b_p0  <= b;
            op_p0 <= op[1:0];
            cnt   <= MULT_LOAD;
            busy  <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            a_p0  <= a;
            b_p0  <= b;
            op_p0 <= op[1:0];
            cnt   <= DIV_LOAD;
            busy  <= 1'b1;
          end
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= a;
          default: ;
        endcase
      end
    end
  end

endmodule
